// File: rtl/circle_overlay_stream.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | circle_overlay_stream                                                    |
// | Two-stage AXI4-Stream stage drawing up to N_CIRCLES ring outlines on RGB |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module circle_overlay_stream #(
  parameter int N_CIRCLES = 4,
  parameter int XW        = 11,
  parameter int YW        = 11,
  parameter int RW        = 10,
  parameter int DW        = 24
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic [N_CIRCLES-1:0]    circle_en,
  input  logic [N_CIRCLES*XW-1:0] circle_cx,
  input  logic [N_CIRCLES*YW-1:0] circle_cy,
  input  logic [N_CIRCLES*RW-1:0] circle_r,
  input  logic [N_CIRCLES*RW-1:0] circle_t,
  input  logic [N_CIRCLES*DW-1:0] circle_rgb,
  input  logic [DW-1:0]           s_axis_tdata,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic                    s_axis_tuser,
  input  logic                    s_axis_tlast,
  output logic [DW-1:0]           m_axis_tdata,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tuser,
  output logic                    m_axis_tlast
);

  localparam int MW  = (XW > YW) ? XW : YW;
  localparam int D2W = 2*MW + 2;
  localparam int CW  = (D2W > 2*RW) ? D2W : 2*RW;

  logic          rdy_q;
  logic          en_w;
  logic          accept_w;
  logic          sof_w;
  logic [XW-1:0] x_q, x_d, bx_w;
  logic [YW-1:0] y_q, y_d, by_w;

  logic          v1_q, user1_q, last1_q;
  logic [DW-1:0] pix1_q;
  logic          v2_q, user2_q, last2_q;
  logic [DW-1:0] data2_q;

  logic [N_CIRCLES-1:0] hit_w;
  logic [DW-1:0]        rgb_w [N_CIRCLES];
  logic [DW-1:0]        out_d;

  assign en_w          = !v2_q | m_axis_tready;
  assign s_axis_tready = en_w & rdy_q;
  assign accept_w      = s_axis_tvalid & s_axis_tready;
  assign sof_w         = accept_w & s_axis_tuser;

  // A start-of-frame beat is pixel (0,0) whatever the counters say.
  assign bx_w = s_axis_tuser ? '0 : x_q;
  assign by_w = s_axis_tuser ? '0 : y_q;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (accept_w) begin
      if (s_axis_tlast) begin
        x_d = '0;
        y_d = (by_w == {YW{1'b1}}) ? by_w : by_w + YW'(1);
      end else begin
        x_d = (bx_w == {XW{1'b1}}) ? bx_w : bx_w + XW'(1);
        y_d = by_w;
      end
    end
  end

  for (genvar i = 0; i < N_CIRCLES; i++) begin : g_slot
    logic          cen_q;
    logic [XW-1:0] ccx_q;
    logic [YW-1:0] ccy_q;
    logic [RW-1:0] cr_q, ct_q;
    logic [DW-1:0] crgb_q;

    logic          cen_w;
    logic [XW-1:0] ccx_w;
    logic [YW-1:0] ccy_w;
    logic [RW-1:0] cr_w, ct_w, inner_w;
    logic [DW-1:0] crgb_w;
    logic [XW:0]   dx_w;
    logic [YW:0]   dy_w;
    logic [XW-1:0] adx_w;
    logic [YW-1:0] ady_w;

    logic            en1_q, small1_q;
    logic [2*XW-1:0] dx2_q;
    logic [2*YW-1:0] dy2_q;
    logic [2*RW-1:0] r2_q, in2_q;
    logic [DW-1:0]   rgb1_q;
    logic [CW-1:0]   d2_w;

    // The start-of-frame pixel already uses the configuration being latched.
    assign cen_w  = sof_w ? circle_en[i]              : cen_q;
    assign ccx_w  = sof_w ? circle_cx[i*XW +: XW]     : ccx_q;
    assign ccy_w  = sof_w ? circle_cy[i*YW +: YW]     : ccy_q;
    assign cr_w   = sof_w ? circle_r[i*RW +: RW]      : cr_q;
    assign ct_w   = sof_w ? circle_t[i*RW +: RW]      : ct_q;
    assign crgb_w = sof_w ? circle_rgb[i*DW +: DW]    : crgb_q;

    assign dx_w    = {1'b0, bx_w} - {1'b0, ccx_w};
    assign dy_w    = {1'b0, by_w} - {1'b0, ccy_w};
    // |d| < 2^W, so negating the low bits alone yields the magnitude.
    assign adx_w   = dx_w[XW] ? ({XW{1'b0}} - dx_w[XW-1:0]) : dx_w[XW-1:0];
    assign ady_w   = dy_w[YW] ? ({YW{1'b0}} - dy_w[YW-1:0]) : dy_w[YW-1:0];
    assign inner_w = cr_w - ct_w;

    always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
        cen_q  <= 1'b0;
        ccx_q  <= '0;
        ccy_q  <= '0;
        cr_q   <= '0;
        ct_q   <= '0;
        crgb_q <= '0;
      end else if (sof_w) begin
        cen_q  <= circle_en[i];
        ccx_q  <= circle_cx[i*XW +: XW];
        ccy_q  <= circle_cy[i*YW +: YW];
        cr_q   <= circle_r[i*RW +: RW];
        ct_q   <= circle_t[i*RW +: RW];
        crgb_q <= circle_rgb[i*DW +: DW];
      end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
        en1_q    <= 1'b0;
        small1_q <= 1'b0;
        dx2_q    <= '0;
        dy2_q    <= '0;
        r2_q     <= '0;
        in2_q    <= '0;
        rgb1_q   <= '0;
      end else if (en_w) begin
        en1_q    <= cen_w;
        small1_q <= (cr_w <= ct_w);
        dx2_q    <= {{XW{1'b0}}, adx_w} * {{XW{1'b0}}, adx_w};
        dy2_q    <= {{YW{1'b0}}, ady_w} * {{YW{1'b0}}, ady_w};
        r2_q     <= {{RW{1'b0}}, cr_w} * {{RW{1'b0}}, cr_w};
        in2_q    <= {{RW{1'b0}}, inner_w} * {{RW{1'b0}}, inner_w};
        rgb1_q   <= crgb_w;
      end
    end

    assign d2_w     = CW'(dx2_q) + CW'(dy2_q);
    assign hit_w[i] = en1_q & (d2_w <= CW'(r2_q)) & (small1_q | (d2_w > CW'(in2_q)));
    assign rgb_w[i] = rgb1_q;
  end

  always_comb begin
    out_d = pix1_q;
    for (int k = N_CIRCLES-1; k >= 0; k--) begin
      if (hit_w[k]) out_d = rgb_w[k];
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rdy_q   <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      v1_q    <= 1'b0;
      user1_q <= 1'b0;
      last1_q <= 1'b0;
      pix1_q  <= '0;
      v2_q    <= 1'b0;
      user2_q <= 1'b0;
      last2_q <= 1'b0;
      data2_q <= '0;
    end else begin
      rdy_q <= 1'b1;
      x_q   <= x_d;
      y_q   <= y_d;
      if (en_w) begin
        v1_q    <= accept_w;
        user1_q <= s_axis_tuser;
        last1_q <= s_axis_tlast;
        pix1_q  <= s_axis_tdata;
        v2_q    <= v1_q;
        user2_q <= user1_q;
        last2_q <= last1_q;
        data2_q <= out_d;
      end
    end
  end

  assign m_axis_tvalid = v2_q;
  assign m_axis_tdata  = data2_q;
  assign m_axis_tuser  = user2_q;
  assign m_axis_tlast  = last2_q;

endmodule
`default_nettype wire

// File: tb/tb_circle_overlay_stream.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_circle_overlay_stream                                                 |
// | Self-checking bench: vector table, corner sequences, random vs. model    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_circle_overlay_stream;
  localparam int N  = 4;
  localparam int XW = 11;
  localparam int YW = 11;
  localparam int RW = 10;
  localparam int DW = 24;
  localparam logic [DW-1:0] RED = 24'hFF0000;
  localparam logic [DW-1:0] GRN = 24'h00FF00;
  localparam logic [DW-1:0] BLU = 24'h0000FF;
  localparam logic [DW-1:0] BLK = 24'h000000;

  logic            ACLK = 1'b0;
  logic            ARESET;
  logic [N-1:0]    circle_en;
  logic [N*XW-1:0] circle_cx;
  logic [N*YW-1:0] circle_cy;
  logic [N*RW-1:0] circle_r;
  logic [N*RW-1:0] circle_t;
  logic [N*DW-1:0] circle_rgb;
  logic [DW-1:0]   s_axis_tdata;
  logic            s_axis_tvalid, s_axis_tready, s_axis_tuser, s_axis_tlast;
  logic [DW-1:0]   m_axis_tdata;
  logic            m_axis_tvalid, m_axis_tready, m_axis_tuser, m_axis_tlast;

  int checks   = 0;
  int failures = 0;

  typedef struct { logic [DW-1:0] d; logic u; logic l; } beat_t;
  typedef struct { int scen; int x; int y; logic [DW-1:0] exp; } vec_t;

  beat_t exp_q[$];
  beat_t got_q[$];

  // Reference model state: per-frame configuration and pixel coordinates.
  int            m_en[N], m_cx[N], m_cy[N], m_r[N], m_t[N];
  logic [DW-1:0] m_rgb[N];
  int            mx = 0, my = 0;

  int            rmode = 0;
  int            ncyc = 0, t_in = -1, t_out = -1;
  bit            lat_arm = 1'b0;
  bit            prev_stall = 1'b0;
  logic [DW+1:0] prev_out = '0;
  int            base0, base1, cnt, errs_u, errs_l;
  vec_t          tbl [13];

  always #5 ACLK = ~ACLK;

  circle_overlay_stream #(
    .N_CIRCLES(N), .XW(XW), .YW(YW), .RW(RW), .DW(DW)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .circle_en(circle_en), .circle_cx(circle_cx), .circle_cy(circle_cy),
    .circle_r(circle_r), .circle_t(circle_t), .circle_rgb(circle_rgb),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tuser(s_axis_tuser),
    .s_axis_tlast(s_axis_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tuser(m_axis_tuser),
    .m_axis_tlast(m_axis_tlast)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    failures++;
    $display("FAIL %s: got no completion, required completion", nm);
  endtask

  function automatic logic [DW-1:0] model_pix(input int px, input int py, input logic [DW-1:0] pix);
    logic [DW-1:0] res;
    bit found;
    int d2, rr, ii;
    res = pix;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      d2 = (px - m_cx[i]) * (px - m_cx[i]) + (py - m_cy[i]) * (py - m_cy[i]);
      rr = m_r[i] * m_r[i];
      ii = (m_r[i] - m_t[i]) * (m_r[i] - m_t[i]);
      if (!found && m_en[i] != 0 && d2 <= rr && (m_r[i] <= m_t[i] || d2 > ii)) begin
        found = 1'b1;
        res = m_rgb[i];
      end
    end
    return res;
  endfunction

  always @(negedge ACLK) begin
    beat_t e, g;
    ncyc++;
    if (ARESET) begin
      exp_q.delete();
      mx = 0;
      my = 0;
      for (int i = 0; i < N; i++) begin
        m_en[i] = 0; m_cx[i] = 0; m_cy[i] = 0; m_r[i] = 0; m_t[i] = 0; m_rgb[i] = '0;
      end
      prev_stall = 1'b0;
    end else begin
      if (s_axis_tvalid && s_axis_tready) begin
        if (s_axis_tuser) begin
          mx = 0;
          my = 0;
          for (int i = 0; i < N; i++) begin
            m_en[i]  = int'(circle_en[i]);
            m_cx[i]  = int'(circle_cx[i*XW +: XW]);
            m_cy[i]  = int'(circle_cy[i*YW +: YW]);
            m_r[i]   = int'(circle_r[i*RW +: RW]);
            m_t[i]   = int'(circle_t[i*RW +: RW]);
            m_rgb[i] = circle_rgb[i*DW +: DW];
          end
        end
        e.d = model_pix(mx, my, s_axis_tdata);
        e.u = s_axis_tuser;
        e.l = s_axis_tlast;
        exp_q.push_back(e);
        if (s_axis_tlast) begin
          mx = 0;
          if (my < 2**YW - 1) my++;
        end else if (mx < 2**XW - 1) begin
          mx++;
        end
        if (lat_arm && t_in < 0) t_in = ncyc;
      end
      if (prev_stall)
        chk("hold_stable", 64'({m_axis_tuser, m_axis_tlast, m_axis_tdata}), 64'(prev_out));
      if (lat_arm && t_in >= 0 && t_out < 0 && m_axis_tvalid) t_out = ncyc;
      if (m_axis_tvalid && m_axis_tready) begin
        g.d = m_axis_tdata;
        g.u = m_axis_tuser;
        g.l = m_axis_tlast;
        got_q.push_back(g);
        if (exp_q.size() == 0) begin
          fail("unexpected_out_beat");
        end else begin
          e = exp_q.pop_front();
          chk("out_beat", 64'({g.u, g.l, g.d}), 64'({e.u, e.l, e.d}));
        end
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_out   = {m_axis_tuser, m_axis_tlast, m_axis_tdata};
    end
  end

  initial begin
    int ph;
    ph = 0;
    m_axis_tready = 1'b1;
    forever begin
      @(posedge ACLK);
      #1;
      ph = (ph + 1) % 3;
      case (rmode)
        1:       m_axis_tready = (ph == 0);
        2:       m_axis_tready = ($urandom_range(3) != 0);
        default: m_axis_tready = 1'b1;
      endcase
    end
  end

  task automatic send(input logic [DW-1:0] d, input logic u, input logic l);
    bit hs;
    int guard;
    hs = 1'b0;
    guard = 0;
    s_axis_tdata  = d;
    s_axis_tuser  = u;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    while (!hs && guard < 1000) begin
      @(negedge ACLK);
      hs = s_axis_tready;
      @(posedge ACLK);
      #1;
      guard++;
    end
    s_axis_tvalid = 1'b0;
    if (!hs) fail("send_timeout");
  endtask

  task automatic send_frame(input int w, input int h, input int dmode, input int gap,
                            input bit use_sof, input int cfg_at, input int cfg_cx);
    logic [DW-1:0] d;
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        if (y*w + x == cfg_at) circle_cx[0 +: XW] = XW'(cfg_cx);
        if (gap > 0 && $urandom_range(99) < gap) begin
          @(posedge ACLK);
          #1;
        end
        case (dmode)
          1:       d = DW'($urandom);
          2:       d = DW'((y*w + x) * 32'h00030507 + 32'h00102030);
          default: d = '0;
        endcase
        send(d, use_sof && x == 0 && y == 0, x == w - 1);
      end
    end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 3000) begin
      @(posedge ACLK);
      #1;
      guard++;
    end
    chk("drain_empty", 64'(exp_q.size()), 64'(0));
    @(posedge ACLK);
    #1;
  endtask

  task automatic set_slot(input int i, input bit en, input int cx, input int cy,
                          input int r, input int t, input logic [DW-1:0] rgb);
    circle_en[i]            = en;
    circle_cx[i*XW +: XW]   = XW'(cx);
    circle_cy[i*YW +: YW]   = YW'(cy);
    circle_r[i*RW +: RW]    = RW'(r);
    circle_t[i*RW +: RW]    = RW'(t);
    circle_rgb[i*DW +: DW]  = rgb;
  endtask

  initial begin
    tbl[0]  = '{0, 6, 4, RED};
    tbl[1]  = '{0, 4, 2, RED};
    tbl[2]  = '{0, 5, 5, RED};
    tbl[3]  = '{0, 3, 3, RED};
    tbl[4]  = '{0, 2, 4, RED};
    tbl[5]  = '{0, 4, 4, BLK};
    tbl[6]  = '{0, 5, 4, BLK};
    tbl[7]  = '{0, 7, 4, BLK};
    tbl[8]  = '{0, 0, 0, BLK};
    tbl[9]  = '{1, 4, 4, GRN};
    tbl[10] = '{1, 6, 4, RED};
    tbl[11] = '{1, 5, 4, GRN};
    tbl[12] = '{1, 7, 4, BLK};

    ARESET = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tdata = '0;
    s_axis_tuser = 1'b0;
    s_axis_tlast = 1'b0;
    circle_en = '0; circle_cx = '0; circle_cy = '0;
    circle_r = '0; circle_t = '0; circle_rgb = '0;
    repeat (3) @(posedge ACLK);
    #1;
    chk("rst_m_valid", 64'(m_axis_tvalid), 64'(0));
    chk("rst_m_data",  64'(m_axis_tdata),  64'(0));
    chk("rst_m_user",  64'(m_axis_tuser),  64'(0));
    chk("rst_m_last",  64'(m_axis_tlast),  64'(0));
    ARESET = 1'b0;
    @(posedge ACLK);
    #1;
    chk("rst_s_ready", 64'(s_axis_tready), 64'(1));

    // Basic ring, 8x8 frame
    set_slot(0, 1'b1, 4, 4, 2, 1, RED);
    lat_arm = 1'b1;
    base0 = got_q.size();
    send_frame(8, 8, 0, 0, 1'b1, -1, 0);
    drain();
    lat_arm = 1'b0;
    chk("latency", 64'(t_out - t_in), 64'(2));
    cnt = 0; errs_u = 0; errs_l = 0;
    for (int i = 0; i < 64; i++) begin
      if (got_q[base0+i].d == RED) cnt++;
      if (got_q[base0+i].l != (i % 8 == 7)) errs_l++;
      if (got_q[base0+i].u != (i == 0)) errs_u++;
    end
    chk("hit_count", 64'(cnt), 64'(8));
    chk("tlast_pos", 64'(errs_l), 64'(0));
    chk("tuser_pos", 64'(errs_u), 64'(0));

    // Priority: filled disc in slot1 under slot0 ring
    set_slot(1, 1'b1, 4, 4, 2, 3, GRN);
    base1 = got_q.size();
    send_frame(8, 8, 0, 0, 1'b1, -1, 0);
    drain();
    for (int i = 0; i < 13; i++)
      chk($sformatf("vec_s%0d_x%0d_y%0d", tbl[i].scen, tbl[i].x, tbl[i].y),
          64'(got_q[(tbl[i].scen == 0 ? base0 : base1) + tbl[i].y*8 + tbl[i].x].d),
          64'(tbl[i].exp));

    // Backpressure: 1-on/2-off vs. no stall must give the same stream
    set_slot(1, 1'b0, 0, 0, 0, 0, BLK);
    rmode = 0;
    base0 = got_q.size();
    send_frame(8, 8, 2, 0, 1'b1, -1, 0);
    drain();
    rmode = 1;
    base1 = got_q.size();
    send_frame(8, 8, 2, 0, 1'b1, -1, 0);
    drain();
    rmode = 0;
    chk("bp_len", 64'(got_q.size() - base1), 64'(64));
    for (int i = 0; i < 64; i++)
      chk("bp_beat", 64'({got_q[base1+i].u, got_q[base1+i].l, got_q[base1+i].d}),
          64'({got_q[base0+i].u, got_q[base0+i].l, got_q[base0+i].d}));

    // Mid-frame reconfigure at (3,3)
    base0 = got_q.size();
    send_frame(8, 8, 0, 0, 1'b1, 27, 1);
    drain();
    chk("reconf_same_frame", 64'(got_q[base0 + 4*8 + 6].d), 64'(RED));
    base1 = got_q.size();
    send_frame(8, 8, 0, 0, 1'b1, -1, 0);
    drain();
    chk("reconf_next_hit", 64'(got_q[base1 + 4*8 + 3].d), 64'(RED));
    chk("reconf_next_old", 64'(got_q[base1 + 4*8 + 6].d), 64'(BLK));

    // Resync: tuser on the 5th pixel of a line
    set_slot(0, 1'b1, 4, 4, 2, 1, RED);
    base0 = got_q.size();
    for (int i = 0; i < 4; i++) send('0, 1'b0, 1'b0);
    send_frame(8, 8, 0, 0, 1'b1, -1, 0);
    drain();
    chk("resync_user", 64'(got_q[base0 + 4].u), 64'(1));
    chk("resync_hit", 64'(got_q[base0 + 4 + 4*8 + 6].d), 64'(RED));
    chk("resync_ctr", 64'(got_q[base0 + 4 + 4*8 + 4].d), 64'(BLK));

    // Reset with the pipeline full
    for (int i = 0; i < 10; i++) send(24'h123456, i == 0, 1'b0);
    ARESET = 1'b1;
    #1;
    chk("rst_mid_valid", 64'(m_axis_tvalid), 64'(0));
    set_slot(0, 1'b1, 2, 4, 2, 1, BLU);
    repeat (2) @(posedge ACLK);
    #1;
    ARESET = 1'b0;
    @(posedge ACLK);
    #1;
    base0 = got_q.size();
    send_frame(8, 8, 0, 0, 1'b0, -1, 0);
    drain();
    cnt = 0;
    for (int i = base0; i < got_q.size(); i++) if (got_q[i].d != BLK) cnt++;
    chk("rst_passthru_len", 64'(got_q.size() - base0), 64'(64));
    chk("rst_passthru_data", 64'(cnt), 64'(0));
    base1 = got_q.size();
    send_frame(8, 8, 0, 0, 1'b1, -1, 0);
    drain();
    chk("rst_newcfg_hit", 64'(got_q[base1 + 4*8 + 4].d), 64'(BLU));
    chk("rst_newcfg_ctr", 64'(got_q[base1 + 4*8 + 2].d), 64'(BLK));

    // Randomised frames, configs, gaps and backpressure against the model
    rmode = 2;
    for (int f = 0; f < 8; f++) begin
      int w, h;
      w = int'($urandom_range(3, 12));
      h = int'($urandom_range(2, 6));
      for (int i = 0; i < N; i++)
        set_slot(i, 1'($urandom_range(1)), int'($urandom_range(0, w + 1)),
                 int'($urandom_range(0, h + 1)), int'($urandom_range(0, 5)),
                 int'($urandom_range(0, 6)), DW'($urandom));
      send_frame(w, h, 1, 30, 1'b1,
                 ($urandom_range(1) == 1) ? int'($urandom_range(0, w*h - 1)) : -1,
                 int'($urandom_range(0, w)));
      drain();
    end
    rmode = 0;

    // Over-long line: x saturates at the last column
    for (int i = 1; i < N; i++) set_slot(i, 1'b0, 0, 0, 0, 0, BLK);
    set_slot(0, 1'b1, 2047, 0, 1, 1, RED);
    base0 = got_q.size();
    for (int k = 0; k < 2050; k++) send('0, k == 0, k == 2049);
    drain();
    chk("sat_edge", 64'(got_q[base0 + 2047].d), 64'(RED));
    chk("sat_over", 64'(got_q[base0 + 2049].d), 64'(RED));
    chk("sat_outside", 64'(got_q[base0 + 2045].d), 64'(BLK));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout, required completion");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
